// File: rtl/eva_pkg.sv
// eva_pkg: shared definitions for the EVA per-age event histogram.
//   - ctr_type_e / ctr_class_e : counter type (EVICT/HIT) and reuse class (NR/R)
//   - snap_state_e             : snapshot bank state (EMPTY/FULL)
//   - rd_class_bit/rd_type_bit : rd_addr layout {type, class, age}
//   - sat_inc                  : saturating increment for counters up to 32 bits
package eva_pkg;

  typedef enum logic {EVICT = 1'b0, HIT = 1'b1} ctr_type_e;
  typedef enum logic {NR = 1'b0, R = 1'b1} ctr_class_e;
  typedef enum logic {SNAP_EMPTY = 1'b0, SNAP_FULL = 1'b1} snap_state_e;

  // rd_addr = {type, class, age[age_w-1:0]}
  function automatic int rd_class_bit(input int age_w);
    return age_w;
  endfunction

  function automatic int rd_type_bit(input int age_w);
    return age_w + 1;
  endfunction

  localparam int SAT_W = 32;

  // Adds inc to val, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic             inc,
                                                input int unsigned      w);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << w) - SAT_W'(1);
    if (inc && (val != max_val)) return val + SAT_W'(1);
    return val;
  endfunction

endpackage

// File: rtl/eva_ctr_bank.sv
// eva_ctr_bank: N live saturating counters plus N snapshot counters for one
// (type, class) pair of the histogram.
//   inc/inc_idx : add one to live counter inc_idx this cycle
//   capture     : copy live counters (pre-update values) into the snapshot
//   decay       : epoch boundary; live counters restart from 0 (DECAY=0) or
//                 old>>1 (DECAY=1) before this cycle's increment is added
//   rd_idx      : selects the snapshot counter driven on rd_val (unregistered)
module eva_ctr_bank
  import eva_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int CTR_W = 10,
  parameter int DECAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             capture,
  input  logic             decay,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_val
);

  logic [CTR_W-1:0] live_q [N];
  logic [CTR_W-1:0] live_d [N];
  logic [CTR_W-1:0] snap_q [N];
  logic [CTR_W-1:0] snap_d [N];
  logic [CTR_W-1:0] base   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (!decay)          base[i] = live_q[i];
      else if (DECAY != 0) base[i] = live_q[i] >> 1;
      else                 base[i] = '0;
      live_d[i] = CTR_W'(sat_inc(SAT_W'(base[i]), inc && (inc_idx == IDX_W'(i)), CTR_W));
      // Snapshot sees the counter as it stood before this cycle's event.
      snap_d[i] = capture ? live_q[i] : snap_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end else begin
        live_q[i] <= live_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign rd_val = snap_q[rd_idx];

endmodule

// File: rtl/eva_histogram.sv
// eva_histogram: per-age hit/eviction histogram split by reuse class, with an
// epoch snapshot bank read by the EVA rank calculator.
//   age_1D, classificationBit : per-line age and reuse class from the tag logic
//   hit_valid/hit_addr        : hit event on one line
//   evict_data/evict_addr     : eviction event on one line
//   epoch_end                 : closes the epoch (snapshot + clear/halve)
//   snap_valid/snap_ack       : snapshot handshake
//   snap_overrun              : sticky, an epoch closed over an unconsumed snapshot
//   rd_en/rd_addr             : read of snapshot counter {type, class, age}
//   rd_data/rd_valid          : registered read result, one cycle after rd_en
module eva_histogram
  import eva_pkg::*;
#(
  parameter int LINES = 32,
  parameter int AGE_W = 3,
  parameter int CTR_W = 10,
  parameter int DECAY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LINES*AGE_W-1:0]   age_1D,
  input  logic [LINES-1:0]         classificationBit,
  input  logic                     hit_valid,
  input  logic [$clog2(LINES)-1:0] hit_addr,
  input  logic                     evict_data,
  input  logic [$clog2(LINES)-1:0] evict_addr,
  input  logic                     epoch_end,
  output logic                     snap_valid,
  input  logic                     snap_ack,
  output logic                     snap_overrun,
  input  logic                     rd_en,
  input  logic [AGE_W+1:0]         rd_addr,
  output logic [CTR_W-1:0]         rd_data,
  output logic                     rd_valid
);

  localparam int N         = 2 ** AGE_W;
  localparam int CLASS_BIT = rd_class_bit(AGE_W);
  localparam int TYPE_BIT  = rd_type_bit(AGE_W);

  // ---------------- event decode ----------------
  logic [AGE_W-1:0] hit_age, ev_age;
  logic             hit_cls, ev_cls;

  assign hit_age = age_1D[hit_addr*AGE_W +: AGE_W];
  assign ev_age  = age_1D[evict_addr*AGE_W +: AGE_W];
  assign hit_cls = classificationBit[hit_addr];
  assign ev_cls  = classificationBit[evict_addr];

  // ---------------- snapshot state machine ----------------
  // Handshake: snap_valid is high while the snapshot bank holds an epoch the
  // consumer has not released; snap_ack (any cycle while valid) releases it
  // on the next edge. An ack arriving with epoch_end is applied first, so the
  // bank is refilled in that same edge and snap_valid stays high.
  snap_state_e state_q;
  logic        overrun_q;
  logic        capture;

  assign capture = epoch_end && ((state_q == SNAP_EMPTY) || snap_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SNAP_EMPTY;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        SNAP_EMPTY: if (epoch_end) state_q <= SNAP_FULL;
        SNAP_FULL: begin
          if (snap_ack && !epoch_end) state_q <= SNAP_EMPTY;
          if (epoch_end && !snap_ack) overrun_q <= 1'b1;
        end
        default: state_q <= SNAP_EMPTY;
      endcase
    end
  end

  assign snap_valid   = (state_q == SNAP_FULL);
  assign snap_overrun = overrun_q;

  // ---------------- counter banks ----------------
  logic [CTR_W-1:0] val_hit_r, val_hit_nr, val_ev_r, val_ev_nr;
  logic [AGE_W-1:0] rd_age;

  assign rd_age = rd_addr[AGE_W-1:0];

  eva_ctr_bank #(.N(N), .IDX_W(AGE_W), .CTR_W(CTR_W), .DECAY(DECAY)) u_hit_r (
    .clk(clk), .rst(rst), .inc(hit_valid && (ctr_class_e'(hit_cls) == R)), .inc_idx(hit_age),
    .capture(capture), .decay(epoch_end), .rd_idx(rd_age), .rd_val(val_hit_r));

  eva_ctr_bank #(.N(N), .IDX_W(AGE_W), .CTR_W(CTR_W), .DECAY(DECAY)) u_hit_nr (
    .clk(clk), .rst(rst), .inc(hit_valid && (ctr_class_e'(hit_cls) == NR)), .inc_idx(hit_age),
    .capture(capture), .decay(epoch_end), .rd_idx(rd_age), .rd_val(val_hit_nr));

  eva_ctr_bank #(.N(N), .IDX_W(AGE_W), .CTR_W(CTR_W), .DECAY(DECAY)) u_ev_r (
    .clk(clk), .rst(rst), .inc(evict_data && (ctr_class_e'(ev_cls) == R)), .inc_idx(ev_age),
    .capture(capture), .decay(epoch_end), .rd_idx(rd_age), .rd_val(val_ev_r));

  eva_ctr_bank #(.N(N), .IDX_W(AGE_W), .CTR_W(CTR_W), .DECAY(DECAY)) u_ev_nr (
    .clk(clk), .rst(rst), .inc(evict_data && (ctr_class_e'(ev_cls) == NR)), .inc_idx(ev_age),
    .capture(capture), .decay(epoch_end), .rd_idx(rd_age), .rd_val(val_ev_nr));

  // ---------------- read mux / register ----------------
  logic [CTR_W-1:0] rd_sel, rd_data_d, rd_data_q;
  logic             rd_valid_d, rd_valid_q;
  ctr_type_e        rd_type;
  ctr_class_e       rd_class;

  always_comb begin
    rd_type  = ctr_type_e'(rd_addr[TYPE_BIT]);
    rd_class = ctr_class_e'(rd_addr[CLASS_BIT]);
    rd_sel   = val_ev_nr;
    if (rd_type == HIT) rd_sel = (rd_class == R) ? val_hit_r : val_hit_nr;
    else                rd_sel = (rd_class == R) ? val_ev_r  : val_ev_nr;
    rd_data_d  = rd_en ? rd_sel : rd_data_q;
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_eva_histogram.sv
// tb_eva_histogram: drives two histogram instances with identical stimulus
// (dut_a: CTR_W=4, DECAY=0; dut_b: CTR_W=10, DECAY=1) and compares both
// against an array-based reference model of the histogram rules.
module tb_eva_histogram;

  localparam int LINES = 32;
  localparam int AGE_W = 3;
  localparam int NB    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [LINES*AGE_W-1:0] age_1d;
  logic [LINES-1:0]       cls_bits;
  logic                   hit_valid, evict_data, epoch_end, snap_ack, rd_en;
  logic [4:0]             hit_addr, evict_addr, rd_addr;

  logic       snap_valid_a, snap_overrun_a, rd_valid_a;
  logic [3:0] rd_data_a;
  logic       snap_valid_b, snap_overrun_b, rd_valid_b;
  logic [9:0] rd_data_b;

  eva_histogram #(.LINES(LINES), .AGE_W(AGE_W), .CTR_W(4), .DECAY(0)) dut_a (
    .clk(clk), .rst(rst), .age_1D(age_1d), .classificationBit(cls_bits),
    .hit_valid(hit_valid), .hit_addr(hit_addr), .evict_data(evict_data),
    .evict_addr(evict_addr), .epoch_end(epoch_end), .snap_valid(snap_valid_a),
    .snap_ack(snap_ack), .snap_overrun(snap_overrun_a), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  eva_histogram #(.LINES(LINES), .AGE_W(AGE_W), .CTR_W(10), .DECAY(1)) dut_b (
    .clk(clk), .rst(rst), .age_1D(age_1d), .classificationBit(cls_bits),
    .hit_valid(hit_valid), .hit_addr(hit_addr), .evict_data(evict_data),
    .evict_addr(evict_addr), .epoch_end(epoch_end), .snap_valid(snap_valid_b),
    .snap_ack(snap_ack), .snap_overrun(snap_overrun_b), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];

  // model: [instance][type 1=hit][class 1=R][age]
  int live_m [2][2][2][NB];
  int snap_m [2][2][2][NB];
  int ages_m [LINES];
  bit cls_m  [LINES];
  int ctr_w_m [2] = '{4, 10};
  int decay_m [2] = '{0, 1};
  int m_rd    [2] = '{0, 0};
  bit m_valid, m_ovr, m_rv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of the reference histogram, using the inputs seen at this edge.
  function automatic void model_update();
    bit cap;
    int v, mx;
    if (rst) begin
      for (int k = 0; k < 2; k++)
        for (int t = 0; t < 2; t++)
          for (int c = 0; c < 2; c++)
            for (int a = 0; a < NB; a++) begin
              live_m[k][t][c][a] = 0;
              snap_m[k][t][c][a] = 0;
            end
      m_valid = 0; m_ovr = 0; m_rv = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else begin
      if (rd_en)
        for (int k = 0; k < 2; k++)
          m_rd[k] = snap_m[k][rd_addr[4]][rd_addr[3]][rd_addr[2:0]];
      m_rv = rd_en;
      cap  = epoch_end && (!m_valid || snap_ack);
      if (epoch_end && m_valid && !snap_ack) m_ovr = 1;
      for (int k = 0; k < 2; k++) begin
        mx = (1 << ctr_w_m[k]) - 1;
        for (int t = 0; t < 2; t++)
          for (int c = 0; c < 2; c++)
            for (int a = 0; a < NB; a++) begin
              if (cap) snap_m[k][t][c][a] = live_m[k][t][c][a];
              v = live_m[k][t][c][a];
              if (epoch_end) v = (decay_m[k] != 0) ? v / 2 : 0;
              if (t == 1 && hit_valid && int'(cls_m[hit_addr]) == c && ages_m[hit_addr] == a) v++;
              if (t == 0 && evict_data && int'(cls_m[evict_addr]) == c && ages_m[evict_addr] == a) v++;
              if (v > mx) v = mx;
              live_m[k][t][c][a] = v;
            end
      end
      if (epoch_end)     m_valid = 1;
      else if (snap_ack) m_valid = 0;
    end
    exp_q_a.push_back(10'(m_rd[0]));
    exp_q_b.push_back(10'(m_rd[1]));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_line(input int i, input int age, input bit c);
    ages_m[i] = age;
    cls_m[i]  = c;
    age_1d[i*AGE_W +: AGE_W] = 3'(age);
    cls_bits[i] = c;
  endtask

  task automatic idle();
    rst = 0; hit_valid = 0; evict_data = 0; epoch_end = 0; snap_ack = 0; rd_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("rd_data_a",      32'(rd_data_a),      32'(exp_q_a.pop_front()));
    check("rd_data_b",      32'(rd_data_b),      32'(exp_q_b.pop_front()));
    check("rd_valid_a",     32'(rd_valid_a),     32'(m_rv));
    check("rd_valid_b",     32'(rd_valid_b),     32'(m_rv));
    check("snap_valid_a",   32'(snap_valid_a),   32'(m_valid));
    check("snap_valid_b",   32'(snap_valid_b),   32'(m_valid));
    check("snap_overrun_a", 32'(snap_overrun_a), 32'(m_ovr));
    check("snap_overrun_b", 32'(snap_overrun_b), 32'(m_ovr));
  endtask

  task automatic read_one(input logic [4:0] addr);
    rd_en = 1; rd_addr = addr;
    step();
    rd_en = 0;
  endtask

  task automatic pulse_epoch();
    epoch_end = 1; step(); epoch_end = 0;
  endtask

  task automatic pulse_ack();
    snap_ack = 1; step(); snap_ack = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    hit_addr = '0; evict_addr = '0; rd_addr = '0;
    age_1d = '0; cls_bits = '0;
    for (int i = 0; i < LINES; i++) set_line(i, 0, 1'b0);

    // reset
    rst = 1; step(); step(); rst = 0;
    check("reset_snap_valid", 32'(snap_valid_a), 32'd0);
    read_one(5'b1_1_011);
    check("reset_read", 32'(rd_data_b), 32'd0);

    // three evictions of line 5 (age 2, R)
    set_line(5, 2, 1'b1);
    evict_data = 1; evict_addr = 5'd5;
    repeat (3) step();
    evict_data = 0;
    pulse_epoch();
    check("t1_snap_valid", 32'(snap_valid_b), 32'd1);
    read_one(5'b0_1_010);
    check("t1_ev_r2_a", 32'(rd_data_a), 32'd3);
    check("t1_ev_r2_b", 32'(rd_data_b), 32'd3);
    read_one(5'b0_0_010);
    check("t1_ev_nr2", 32'(rd_data_a), 32'd0);
    pulse_ack();

    // saturation: 20 hits on line 1 (age 3, NR), 4-bit counters hold at 15
    set_line(1, 3, 1'b0);
    hit_valid = 1; hit_addr = 5'd1;
    repeat (20) step();
    hit_valid = 0;
    pulse_epoch();
    read_one(5'b1_0_011);
    check("sat_a", 32'(rd_data_a), 32'd15);
    check("sat_b", 32'(rd_data_b), 32'd20);
    pulse_ack();

    // hit + evict on line 0 (age 7, NR) in the epoch_end cycle
    set_line(0, 7, 1'b0);
    hit_valid = 1; hit_addr = 5'd0; evict_data = 1; evict_addr = 5'd0;
    pulse_epoch();
    hit_valid = 0; evict_data = 0;
    read_one(5'b1_0_111);
    check("same_cyc_excl", 32'(rd_data_a), 32'd0);
    pulse_ack();
    pulse_epoch();
    read_one(5'b1_0_111);
    check("same_cyc_hit", 32'(rd_data_a), 32'd1);
    read_one(5'b0_0_111);
    check("same_cyc_ev", 32'(rd_data_a), 32'd1);
    pulse_ack();

    // decay: EV_R[4] = 9
    set_line(6, 4, 1'b1);
    evict_data = 1; evict_addr = 5'd6;
    repeat (9) step();
    evict_data = 0;
    pulse_epoch();
    read_one(5'b0_1_100);
    check("decay_snap_b", 32'(rd_data_b), 32'd9);
    pulse_ack();
    pulse_epoch();
    read_one(5'b0_1_100);
    check("decay_half_b", 32'(rd_data_b), 32'd4);
    check("decay_clear_a", 32'(rd_data_a), 32'd0);
    pulse_ack();

    // overrun: live EV_R[4] in dut_b is 2 here
    pulse_epoch();
    pulse_epoch();
    check("overrun_set", 32'(snap_overrun_a), 32'd1);
    read_one(5'b0_1_100);
    check("overrun_keep_b", 32'(rd_data_b), 32'd2);
    snap_ack = 1; epoch_end = 1; step(); snap_ack = 0; epoch_end = 0;
    check("ack_epoch_valid", 32'(snap_valid_b), 32'd1);
    read_one(5'b0_1_100);
    check("ack_epoch_new_b", 32'(rd_data_b), 32'd0);

    // reset mid-epoch with counters live, overriding other inputs
    hit_valid = 1; hit_addr = 5'd5;
    repeat (4) step();
    rst = 1; epoch_end = 1; snap_ack = 1;
    step();
    idle();
    check("rst_valid", 32'(snap_valid_a), 32'd0);
    check("rst_overrun", 32'(snap_overrun_b), 32'd0);
    pulse_epoch();
    read_one(5'b1_1_010);
    check("rst_discard_a", 32'(rd_data_a), 32'd0);
    check("rst_discard_b", 32'(rd_data_b), 32'd0);
    pulse_ack();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0)
        for (int i = 0; i < LINES; i++)
          set_line(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      rst        = ($urandom_range(0, 999) == 0);
      hit_valid  = 1'($urandom_range(0, 1));
      hit_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      evict_data = 1'($urandom_range(0, 1));
      evict_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      epoch_end  = ($urandom_range(0, 59) == 0);
      snap_ack   = ($urandom_range(0, 7) == 0);
      rd_en      = 1'($urandom_range(0, 1));
      rd_addr    = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
